// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle core controller and its datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       retire;
  logic       bus_err;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    output alu_src_a, alu_src_b, alu_op, result_src, retire, bus_err, illegal, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
    input  alu_src_a, alu_src_b, alu_op, result_src, retire, bus_err, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore main control FSM for the multi-cycle RV32I core, with memory wait-timeout.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STOR = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Encoding is visible on the debug state port.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_wait;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_wait_clr;
  logic             w_pc_write, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0]       w_src_a, w_src_b, w_alu_op, w_result_src;
  logic             w_retire, w_bus_err;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout   = (WAIT_LIMIT > 0) && w_mem_state && !bus.mem_ready && (r_wait == LAST);
  // Re-entering FETCH after a fetch timeout must also restart the count.
  assign w_wait_clr  = (w_state_next != r_state) || w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_wait_clr)
        r_wait <= '0;
      else if (w_mem_state && !bus.mem_ready)
        r_wait <= r_wait + CNT_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    w_retire     = 1'b0;
    w_bus_err    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        case (bus.opcode)
          OP_R:            w_state_next = S_EXEC_R;
          OP_I:            w_state_next = S_EXEC_I;
          OP_LOAD,OP_STOR: w_state_next = S_MEM_ADDR;
          OP_BR:           w_state_next = S_BRANCH;
          OP_JAL:          w_state_next = S_JAL;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            w_state_next = S_TRAP;
`else
            w_state_next = S_FETCH;
            w_retire     = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        w_src_a      = 2'b10;
        w_alu_op     = 2'b10;
        w_state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_alu_op     = 2'b10;
        w_state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_state_next = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_adr_src  = 1'b1;
        if (bus.mem_ready) begin
          w_state_next = S_WB_MEM;
        end else if (w_timeout) begin
          w_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_WB_MEM: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (bus.mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_bus_err    = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_BRANCH: begin
        w_src_a      = 2'b10;
        w_alu_op     = 2'b01;
        w_pc_write   = bus.zero;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JAL: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_pc_write   = 1'b1;
        w_state_next = S_WB_ALU;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        w_state_next = S_TRAP;
`else
        w_state_next = S_FETCH;
`endif
      end
      default: w_state_next = S_FETCH;
    endcase
    // Reset silences every strobe and select regardless of state.
    if (rst) begin
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_adr_src    = 1'b0;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_reg_write  = 1'b0;
      w_src_a      = 2'b00;
      w_src_b      = 2'b00;
      w_alu_op     = 2'b00;
      w_result_src = 2'b00;
      w_retire     = 1'b0;
      w_bus_err    = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (rst)
      r_illegal <= 1'b0;
    else if (w_state_next == S_TRAP)
      r_illegal <= 1'b1;
  end
  assign bus.illegal = r_illegal;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.pc_write   = w_pc_write;
  assign bus.ir_write   = w_ir_write;
  assign bus.adr_src    = w_adr_src;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.reg_write  = w_reg_write;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.result_src = w_result_src;
  assign bus.retire     = w_retire;
  assign bus.bus_err    = w_bus_err;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: per-instruction phase model
// plus an independent latency formula checked against the observed retire cycle.
module tb_multicycle_ctrl;
  localparam int WL = 16;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                         S_WB_ALU = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_WB_MEM = 4'd7,
                         S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus();
  multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;
  int ret_at = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit known(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_BR) || (op == OP_JAL);
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read, bus.mem_write, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
            bus.retire, bus.bus_err, bus.illegal};
  endfunction

  // Output table of each state, as the control word the datapath should see.
  function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic [6:0] op,
                                          input logic mr, input logic z, input logic be);
    logic pcw, irw, adr, mrd, mwr, rw, ret, ill;
    logic [1:0] a, b, alu, rs;
    {pcw, irw, adr, mrd, mwr, rw, ret, ill} = '0;
    {a, b, alu, rs} = '0;
    case (st)
      S_FETCH:    begin mrd = 1; b = 2; rs = 2; pcw = mr; irw = mr; end
      S_DECODE:   begin a = 1; b = 1; ret = !TRAP_BUILD && !known(op); end
      S_EXEC_R:   begin a = 2; alu = 2; end
      S_EXEC_I:   begin a = 2; b = 1; alu = 2; end
      S_WB_ALU:   begin rw = 1; ret = 1; end
      S_MEM_ADDR: begin a = 2; b = 1; end
      S_MEM_RD:   begin mrd = 1; adr = 1; end
      S_WB_MEM:   begin rs = 1; rw = 1; ret = 1; end
      S_MEM_WR:   begin mwr = 1; adr = 1; ret = mr; end
      S_BRANCH:   begin a = 2; alu = 1; pcw = z; ret = 1; end
      S_JAL:      begin a = 1; b = 2; pcw = 1; end
      S_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pcw, irw, adr, mrd, mwr, rw, a, b, alu, rs, ret, be, ill};
  endfunction

  // Entered at a negedge; drives inputs, checks outputs, returns at the next negedge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] op,
                     input logic mr, input logic z, input logic be);
    bus.mem_ready = mr;
    bus.zero      = z;
    #1;
    check({tag, "/state"}, 32'(bus.state), 32'(st));
    check({tag, "/out"}, 32'(obs_vec()), 32'(exp_vec(st, op, mr, z, be)));
    if (bus.retire === 1'b1 && ret_at < 0) ret_at = ncyc;
    ncyc++;
    @(negedge clk);
  endtask

  task automatic mem_phase(input string tag, input logic [3:0] st, input logic [6:0] op,
                           input int w, output bit to);
    logic mr, be;
    to = 1'b0;
    for (int k = 0; k < WL; k++) begin
      mr = (k >= w);
      be = !mr && (k == WL - 1);
      cyc(tag, st, op, mr, 1'b0, be);
      if (mr) return;
      if (be) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input int fw,
                           input int mw, input logic z);
    bit to, mto;
    int lat;
    bus.opcode = op;
    ncyc   = 0;
    ret_at = -1;
    mto    = 1'b0;
    mem_phase(tag, S_FETCH, op, fw, to);
    if (to) mem_phase(tag, S_FETCH, op, 0, to);
    cyc(tag, S_DECODE, op, 1'b0, z, 1'b0);
    case (op)
      OP_R:   begin cyc(tag, S_EXEC_R, op, 0, z, 0); cyc(tag, S_WB_ALU, op, 0, z, 0); end
      OP_I:   begin cyc(tag, S_EXEC_I, op, 0, z, 0); cyc(tag, S_WB_ALU, op, 0, z, 0); end
      OP_JAL: begin cyc(tag, S_JAL, op, 0, z, 0); cyc(tag, S_WB_ALU, op, 0, z, 0); end
      OP_BR:  cyc(tag, S_BRANCH, op, 0, z, 0);
      OP_LD: begin
        cyc(tag, S_MEM_ADDR, op, 0, z, 0);
        mem_phase(tag, S_MEM_RD, op, mw, mto);
        if (!mto) cyc(tag, S_WB_MEM, op, 0, z, 0);
      end
      OP_ST: begin
        cyc(tag, S_MEM_ADDR, op, 0, z, 0);
        mem_phase(tag, S_MEM_WR, op, mw, mto);
      end
      default: ;
    endcase
    // Latency in cycles from the start of fetch to the retire pulse, inclusive.
    lat = (fw >= WL) ? WL + 1 : fw + 1;
    case (op)
      OP_R, OP_I, OP_JAL: lat += 3;
      OP_LD:              lat += 4 + mw;
      OP_ST:              lat += 3 + mw;
      OP_BR:              lat += 2;
      default:            lat += 1;
    endcase
    if (mw >= WL && (op == OP_LD || op == OP_ST)) lat = 0;
    check({tag, "/latency"}, 32'(ret_at + 1), 32'(lat));
  endtask

  int r, fw, mw;
  logic [6:0] op;
  logic [6:0] bad_ops [4] = '{7'b0000000, 7'b1110011, 7'b0110111, 7'b1111111};

  initial begin
    bus.opcode    = OP_I;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("reset/state", 32'(bus.state), 32'(S_FETCH));
    check("reset/out", 32'(obs_vec()), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_instr("addi", OP_I, 0, 0, 1'b0);
    run_instr("add", OP_R, 0, 0, 1'b0);
    run_instr("lw_wait3", OP_LD, 0, 3, 1'b0);
    run_instr("sw_wait2", OP_ST, 1, 2, 1'b0);
    run_instr("beq_taken", OP_BR, 0, 0, 1'b1);
    run_instr("beq_not", OP_BR, 0, 0, 1'b0);
    run_instr("jal", OP_JAL, 0, 0, 1'b0);
    run_instr("fetch_timeout", OP_I, WL, 0, 1'b0);
    run_instr("fetch_lastcycle", OP_I, WL - 1, 0, 1'b0);
    run_instr("lw_timeout", OP_LD, 0, WL, 1'b0);
    run_instr("sw_timeout", OP_ST, 0, WL + 3, 1'b0);
    run_instr("sw_lastcycle", OP_ST, 0, WL - 1, 1'b0);

    // Reset asserted for one cycle while a load waits in MEM_RD.
    bus.opcode = OP_LD;
    cyc("rst_mid", S_FETCH, OP_LD, 1'b1, 1'b0, 1'b0);
    cyc("rst_mid", S_DECODE, OP_LD, 1'b0, 1'b0, 1'b0);
    cyc("rst_mid", S_MEM_ADDR, OP_LD, 1'b0, 1'b0, 1'b0);
    cyc("rst_mid", S_MEM_RD, OP_LD, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid/state_in_rst", 32'(bus.state), 32'(S_MEM_RD));
    check("rst_mid/out_in_rst", 32'(obs_vec()), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_instr("after_rst", OP_I, 2, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LD;
        3: op = OP_ST;
        4: op = OP_BR;
        5: op = OP_JAL;
        default: op = TRAP_BUILD ? OP_I : bad_ops[$urandom_range(0, 3)];
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(WL - 1, WL + 1) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(WL - 1, WL + 1) : $urandom_range(0, 3);
      run_instr("rand", op, fw, mw, 1'($urandom_range(0, 1)));
    end

    // Unknown opcode: traps in the trap build, otherwise retires as a NOP.
    bus.opcode = 7'b0000000;
    ncyc   = 0;
    ret_at = -1;
    cyc("illegal", S_FETCH, 7'b0, 1'b1, 1'b0, 1'b0);
    cyc("illegal", S_DECODE, 7'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc("illegal", TRAP_BUILD ? S_TRAP : S_FETCH, 7'b0, 1'b0, 1'b0, 1'b0);
    check("illegal/retire", 32'(ret_at + 1), TRAP_BUILD ? 32'd0 : 32'd2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("illegal/cleared", 32'(bus.illegal), 32'd0);
    check("illegal/rst_state", 32'(bus.state), 32'(S_FETCH));
    @(negedge clk);
    rst = 1'b0;
    run_instr("post_illegal", OP_I, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, PC, IR, register file and unified memory through FETCH/DECODE/EXEC/MEM/WB states.
- Drives ALU operand selects and a 2-bit alu_op; the existing funct3-based ALU decoder expands alu_op=10 into the final ALU control.
- Handshakes with memory via mem_ready; optional wait-timeout.

Parameters:
- WAIT_LIMIT, 16, max cycles a memory access may wait for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  load PC from result bus
- ir_write  out  1  latch fetched instruction and old_pc
- adr_src  out  1  memory address: 0=PC, 1=alu_out
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write
- alu_src_a  out  2  00=PC, 01=old_pc, 10=rs1 reg
- alu_src_b  out  2  00=rs2 reg, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- result_src  out  2  00=alu_out reg, 01=mem data, 10=ALU result
- retire  out  1  one-cycle pulse when an instruction completes
- bus_err  out  1  one-cycle pulse on memory timeout
- illegal  out  1  illegal-opcode flag (see Optional Feature)
- state  out  4  current state, debug

Behaviour:
- State register updates on posedge clk. rst=1 sets state=FETCH and the wait counter to 0 at the next edge, regardless of current state.
- While rst=1, all strobes (pc_write, ir_write, mem_read, mem_write, reg_write, retire, bus_err) are forced 0. Selects are 0. illegal resets to 0.
- Unlisted outputs are 0 in each state. Selects not listed are 00.
- FETCH: mem_read=1, adr_src=0, a=00, b=10, op=00, result_src=10. ir_write and pc_write=1 only in the cycle mem_ready=1. Stays in FETCH until mem_ready, then -> DECODE.
- DECODE: a=01, b=01, op=00 (branch/JAL target into alu_out). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> see Optional Feature
- EXEC_R: a=10, b=00, op=10 -> WB_ALU.
- EXEC_I: a=10, b=01, op=10 -> WB_ALU.
- WB_ALU: result_src=00, reg_write=1, retire=1 -> FETCH.
- MEM_ADDR: a=10, b=01, op=00 -> MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: mem_read=1, adr_src=1. Waits for mem_ready -> WB_MEM.
- WB_MEM: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEM_WR: mem_write=1, adr_src=1. Waits for mem_ready, then retire=1 in that cycle -> FETCH.
- BRANCH: a=10, b=00, op=01, result_src=00, pc_write=zero, retire=1 -> FETCH.
- JAL: a=01, b=10, op=00, result_src=00, pc_write=1 -> WB_ALU. JAL retires in WB_ALU with rd=old_pc+4.
- Wait counter (memory states FETCH, MEM_RD, MEM_WR):
  - Clears on entering any memory state and increments each cycle mem_ready=0.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT-1 with mem_ready=0: bus_err=1 for that cycle, all strobes drop next cycle, state -> FETCH with no retire. A FETCH timeout re-fetches the same PC.
  - mem_ready=1 in the same cycle as the limit takes priority: normal completion, no bus_err.
- Strobes stay asserted and stable while waiting; the memory may hold mem_ready high for any duration, but only the first cycle counts.
- Latency with mem_ready immediately high:
  - ALU ops 4 cycles
  - load 5
  - store 4
  - branch 3
  - JAL 4

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP holds with all strobes 0; illegal=1 and stays set until rst. No retire.
- Undefined: an unknown opcode is a NOP. DECODE -> FETCH with retire=1, and illegal is tied 0.

Test Plan:
- Reset mid-MEM_RD (state=MEM_RD, rst=1 one cycle) -> next cycle state=FETCH, mem_read=0 during rst; after release, FETCH issues mem_read=1, adr_src=0.
- addi (opcode 0010011), mem_ready=1 always -> states FETCH, DECODE, EXEC_I, WB_ALU. reg_write=1 and retire=1 only in cycle 4; alu_op=10 in EXEC_I.
- lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read stays 1 for 4 cycles, then WB_MEM with result_src=01 and reg_write=1; total 8 cycles.
- beq with zero=1, then zero=0 -> BRANCH asserts pc_write=1, then pc_write=0; both retire after 3 cycles.
- WAIT_LIMIT=16, mem_ready held 0 in FETCH -> bus_err pulses in the 16th cycle, state returns to FETCH, no retire. Repeat with mem_ready=1 in the 16th cycle -> no bus_err, DECODE follows.
- Opcode 0000000 -> with ILLEGAL_TRAP_EN: state=TRAP, illegal=1 sticky. Without it: returns to FETCH, retire=1, illegal=0.
